// File: rtl/mon_evt_pkg.sv
// -----------------------------------------------------------------------------
// mon_evt_pkg
// Shared constants for the monitor event scheduler:
//   - interrupt/event codes written to host register 0x41
//   - scheduler phase encoding (also visible on the phase output)
//   - video format codes reported by the format detector
//   - slot-dependent threshold helper
// -----------------------------------------------------------------------------
package mon_evt_pkg;

  // Values of register 0x41. FF means "nothing pending".
  localparam logic [7:0] IRQ_NONE = 8'hFF;
  localparam logic [7:0] IRQ_BOOT = 8'hFD;
  localparam logic [7:0] IRQ_PH1  = 8'hFB;
  localparam logic [7:0] IRQ_PH2  = 8'hEF;
  localparam logic [7:0] IRQ_FMT  = 8'hDF;

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    WAIT_ID = 3'd1,
    PH1     = 3'd2,
    PH2     = 3'd3,
    RUN     = 3'd4
  } phase_e;

  // Format codes from the detector. 576I/480I are the SD formats.
  localparam logic [7:0] FMT_NO_SIGNAL = 8'h00;
  localparam logic [7:0] FMT_576I      = 8'h01;
  localparam logic [7:0] FMT_480I      = 8'h02;
  localparam logic [7:0] FMT_576P      = 8'h03;
  localparam logic [7:0] FMT_480P      = 8'h04;

  // Slots 3 and 4 sit further down the power-up chain and get extra time.
  // 9 bits so base + 2*step cannot wrap for any sane parameter set.
  function automatic logic [8:0] slot_threshold(input logic [8:0] base_s,
                                                input logic [8:0] step_s,
                                                input logic [7:0] slot);
    logic [8:0] thr;
    thr = base_s;
    if (slot == 8'd3) begin
      thr = base_s + step_s;
    end else if (slot == 8'd4) begin
      thr = base_s + (step_s << 1);
    end
    return thr;
  endfunction

endpackage

// File: rtl/mon_tick_gen.sv
// -----------------------------------------------------------------------------
// mon_tick_gen
// Millisecond tick and seconds-since-reset counter for the scheduler.
//   clk_50mhz_in  in   system clock
//   reset_x       in   asynchronous active-low reset
//   ms_tick_o     out  one-cycle pulse every CLK_HZ/1000 cycles
//   elapsed_s_o   out  seconds since reset, saturating at 255
// The seconds divider counts raw clocks rather than ms ticks so the second
// boundary stays exact even when CLK_HZ is not a multiple of 1000.
// -----------------------------------------------------------------------------
module mon_tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_x,
  output logic       ms_tick_o,
  output logic [7:0] elapsed_s_o
);

  localparam int MS_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int S_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_DIV - 1);
  localparam logic [S_W-1:0]  S_LAST  = S_W'(CLK_HZ - 1);

  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [S_W-1:0]  s_cnt_q, s_cnt_d;
  logic [7:0]      elapsed_q, elapsed_d;
  logic            s_tick;

  always_comb begin
    ms_tick_o = (ms_cnt_q == MS_LAST);
    s_tick    = (s_cnt_q == S_LAST);
    ms_cnt_d  = ms_tick_o ? '0 : ms_cnt_q + 1'b1;
    s_cnt_d   = s_tick ? '0 : s_cnt_q + 1'b1;
    elapsed_d = elapsed_q;
    if (s_tick && (elapsed_q != 8'hFF)) begin
      elapsed_d = elapsed_q + 8'd1;
    end
  end

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      ms_cnt_q  <= '0;
      s_cnt_q   <= '0;
      elapsed_q <= 8'd0;
    end else begin
      ms_cnt_q  <= ms_cnt_d;
      s_cnt_q   <= s_cnt_d;
      elapsed_q <= elapsed_d;
    end
  end

  assign elapsed_s_o = elapsed_q;

endmodule

// File: rtl/monitor_event_scheduler.sv
// -----------------------------------------------------------------------------
// monitor_event_scheduler
// Sequences register 0x41 toward the BVM-A monitor: boot, ID-read wait,
// phase-1 (FB), phase-2 (EF), then debounced video-format events (DF).
// Ports:
//   clk_50mhz_in      in   50 MHz system clock
//   reset_x           in   asynchronous active-low reset
//   slot_no[7:0]      in   slot number (quasi-static, host written)
//   id_read           in   level from bus domain, 2-flop synchronised
//   irq_clr_tgl       in   toggles once per host write to 0x41 (bus domain)
//   video_format[7:0] in   live format code from the detector
//   irq_reg[7:0]      out  value of register 0x41
//   irq_pending       out  irq_reg != FF
//   reg_video_format  out  format last posted to the monitor
//   hd_sd_x           out  0 for 576I/480I, else 1
//   phase[2:0]        out  current scheduler state
//   elapsed_s[7:0]    out  seconds since reset, saturating
// Build option MON_EVT_WATCHDOG_EN: a code left pending for 5 s in
// PH1/PH2/RUN is dropped to FF for one cycle and re-posted; adds the
// wdt_retries[3:0] output (saturating retry count).
// -----------------------------------------------------------------------------
module monitor_event_scheduler
  import mon_evt_pkg::*;
#(
  parameter int CLK_HZ        = 50000000,
  parameter int PH1_BASE_S    = 12,
  parameter int PH2_BASE_S    = 19,
  parameter int SLOT_STEP_S   = 2,
  parameter int FMT_STABLE_MS = 100
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_x,
  input  logic [7:0] slot_no,
  input  logic       id_read,
  input  logic       irq_clr_tgl,
  input  logic [7:0] video_format,
  output logic [7:0] irq_reg,
  output logic       irq_pending,
  output logic [7:0] reg_video_format,
  output logic       hd_sd_x,
  output logic [2:0] phase,
  output logic [7:0] elapsed_s
`ifdef MON_EVT_WATCHDOG_EN
  ,
  output logic [3:0] wdt_retries
`endif
);

  localparam int DEB_W = $clog2(FMT_STABLE_MS + 1);
  localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(FMT_STABLE_MS);

  phase_e     state_q, state_d;
  logic [7:0] irq_q, irq_d;
  logic [7:0] fmt_q, fmt_d;
  logic [1:0] id_sync_q;
  logic [2:0] clr_sync_q;
  logic       clr_pulse;
  logic       id_sync;
  logic       ms_tick;
  logic [8:0] ph1_thr, ph2_thr;
  logic [7:0] deb_fmt_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic       deb_stable;
  logic       hold_fsm;
  logic       post_ok;

  mon_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_50mhz_in (clk_50mhz_in),
    .reset_x      (reset_x),
    .ms_tick_o    (ms_tick),
    .elapsed_s_o  (elapsed_s)
  );

  assign id_sync   = id_sync_q[1];
  // Flop 0 may be metastable; the edge is detected between flops 1 and 2.
  assign clr_pulse = clr_sync_q[1] ^ clr_sync_q[2];

  // Re-evaluated every cycle so a late slot_no write applies at once.
  assign ph1_thr = slot_threshold(9'(PH1_BASE_S), 9'(SLOT_STEP_S), slot_no);
  assign ph2_thr = slot_threshold(9'(PH2_BASE_S), 9'(SLOT_STEP_S), slot_no);

  assign deb_stable = (deb_cnt_q == DEB_DONE);

  // Format debounce: runs in every state so a format seen during power-up
  // is already qualified when RUN is reached.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      deb_fmt_q <= FMT_NO_SIGNAL;
      deb_cnt_q <= '0;
    end else if (video_format != deb_fmt_q) begin
      deb_fmt_q <= video_format;
      deb_cnt_q <= '0;
    end else if (ms_tick && !deb_stable) begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

`ifdef MON_EVT_WATCHDOG_EN
  localparam int WDT_CYCLES = 5 * CLK_HZ;
  localparam int WDT_W      = $clog2(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             repost_q, repost_d;
  logic [7:0]       saved_q, saved_d;
  logic [3:0]       retries_q, retries_d;
  logic             wdt_counting;
  logic             wdt_fire;

  assign wdt_counting = ((state_q == PH1) || (state_q == PH2) || (state_q == RUN)) &&
                        (irq_q != IRQ_NONE) && !repost_q;
  assign wdt_fire     = wdt_counting && (wdt_cnt_q == WDT_LAST);
  // The forced FF cycle must not look like a host clear to the FSM.
  assign hold_fsm     = repost_q;
  assign wdt_retries  = retries_q;
`else
  assign hold_fsm = 1'b0;
`endif

  assign post_ok = !clr_pulse && !hold_fsm;

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    fmt_d   = fmt_q;
`ifdef MON_EVT_WATCHDOG_EN
    repost_d  = 1'b0;
    saved_d   = saved_q;
    retries_d = retries_q;
    wdt_cnt_d = (wdt_counting && !wdt_fire) ? wdt_cnt_q + 1'b1 : '0;
`endif
    unique case (state_q)
      BOOT: begin
        if (irq_q == IRQ_NONE) state_d = WAIT_ID;
      end
      WAIT_ID: begin
        if (post_ok && id_sync && ({1'b0, elapsed_s} > ph1_thr)) begin
          irq_d   = IRQ_PH1;
          state_d = PH1;
        end
      end
      PH1: begin
        if (post_ok && (irq_q == IRQ_NONE) && ({1'b0, elapsed_s} > ph2_thr)) begin
          irq_d   = IRQ_PH2;
          state_d = PH2;
        end
      end
      PH2: begin
        if (!hold_fsm && (irq_q == IRQ_NONE)) state_d = RUN;
      end
      RUN: begin
        // A change seen while DF is pending waits here until the clear.
        if (post_ok && (irq_q == IRQ_NONE) && deb_stable && (deb_fmt_q != fmt_q)) begin
          fmt_d = deb_fmt_q;
          irq_d = IRQ_FMT;
        end
      end
      default: state_d = BOOT;
    endcase
    // A clear always wins; any post it masked is retried next cycle,
    // which guarantees one idle FF cycle between events.
    if (clr_pulse) begin
      irq_d = IRQ_NONE;
    end
`ifdef MON_EVT_WATCHDOG_EN
    else if (repost_q) begin
      irq_d = saved_q;
    end else if (wdt_fire) begin
      irq_d     = IRQ_NONE;
      repost_d  = 1'b1;
      saved_d   = irq_q;
      retries_d = (retries_q == 4'hF) ? retries_q : retries_q + 4'd1;
    end
`endif
  end

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      state_q    <= BOOT;
      irq_q      <= IRQ_BOOT;
      fmt_q      <= FMT_NO_SIGNAL;
      id_sync_q  <= 2'b00;
      clr_sync_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      fmt_q      <= fmt_d;
      id_sync_q  <= {id_sync_q[0], id_read};
      clr_sync_q <= {clr_sync_q[1:0], irq_clr_tgl};
    end
  end

`ifdef MON_EVT_WATCHDOG_EN
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      wdt_cnt_q <= '0;
      repost_q  <= 1'b0;
      saved_q   <= IRQ_NONE;
      retries_q <= 4'd0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      repost_q  <= repost_d;
      saved_q   <= saved_d;
      retries_q <= retries_d;
    end
  end
`endif

  assign irq_reg          = irq_q;
  assign irq_pending      = (irq_q != IRQ_NONE);
  assign reg_video_format = fmt_q;
  assign hd_sd_x          = !((fmt_q == FMT_576I) || (fmt_q == FMT_480I));
  assign phase            = state_q;

endmodule

// File: tb/tb_monitor_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_monitor_event_scheduler
// Directed bench with CLK_HZ scaled to 1000: one ms tick per clock, one
// second per 1000 clocks. Slot 3 gives thresholds 14 s (phase 1) and 21 s
// (phase 2). Outputs are sampled on the falling edge; inputs change there.
// -----------------------------------------------------------------------------
module tb_monitor_event_scheduler;
  import mon_evt_pkg::*;

  logic       clk = 1'b0;
  logic       reset_x = 1'b1;
  logic [7:0] slot_no = 8'd3;
  logic       id_read = 1'b0;
  logic       irq_clr_tgl = 1'b0;
  logic [7:0] video_format = 8'h00;
  logic [7:0] irq_reg;
  logic       irq_pending;
  logic [7:0] reg_video_format;
  logic       hd_sd_x;
  logic [2:0] phase;
  logic [7:0] elapsed_s;
`ifdef MON_EVT_WATCHDOG_EN
  logic [3:0] wdt_retries;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  monitor_event_scheduler #(.CLK_HZ(1000)) dut (
    .clk_50mhz_in     (clk),
    .reset_x          (reset_x),
    .slot_no          (slot_no),
    .id_read          (id_read),
    .irq_clr_tgl      (irq_clr_tgl),
    .video_format     (video_format),
    .irq_reg          (irq_reg),
    .irq_pending      (irq_pending),
    .reg_video_format (reg_video_format),
    .hd_sd_x          (hd_sd_x),
    .phase            (phase),
    .elapsed_s        (elapsed_s)
`ifdef MON_EVT_WATCHDOG_EN
    ,
    .wdt_retries      (wdt_retries)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_x = 1'b1; slot_no = 8'd3; id_read = 1'b0; irq_clr_tgl = 1'b0; video_format = FMT_NO_SIGNAL;
    #1 reset_x = 1'b0;
    tick(3);
    checks++; if (irq_reg !== IRQ_BOOT) begin errors++; $display("FAIL reset_irq: got %h want %h", irq_reg, IRQ_BOOT); end
    checks++; if (irq_pending !== 1'b1) begin errors++; $display("FAIL reset_pending: got %b want 1", irq_pending); end
    checks++; if (reg_video_format !== 8'h00) begin errors++; $display("FAIL reset_fmt: got %h want 00", reg_video_format); end
    checks++; if (hd_sd_x !== 1'b1) begin errors++; $display("FAIL reset_hdsd: got %b want 1", hd_sd_x); end
    checks++; if (phase !== 3'(BOOT)) begin errors++; $display("FAIL reset_phase: got %0d want %0d", phase, BOOT); end
    checks++; if (elapsed_s !== 8'd0) begin errors++; $display("FAIL reset_elapsed: got %0d want 0", elapsed_s); end
    reset_x = 1'b1;
    $display("test_reset: irq=%h phase=%0d", irq_reg, phase);
  endtask

  task automatic test_boot_clear();
    bit found = 0;
    irq_clr_tgl = ~irq_clr_tgl;
    for (int i = 0; i < 4 && !found; i++) begin
      tick(1);
      if (irq_reg === IRQ_NONE) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL boot_clr: irq got %h want FF within 4 cycles", irq_reg); end
    tick(1);
    checks++; if (phase !== 3'(WAIT_ID)) begin errors++; $display("FAIL boot_phase: got %0d want %0d", phase, WAIT_ID); end
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL boot_pending: got %b want 0", irq_pending); end
    $display("test_boot_clear: irq=%h phase=%0d", irq_reg, phase);
  endtask

  task automatic test_phase1();
    int n = 0;
    while (elapsed_s < 8'd5 && n < 8000) begin tick(1); n++; end
    id_read = 1'b1;
    n = 0;
    while (elapsed_s !== 8'd15 && n < 20000) begin tick(1); n++; end
    checks++; if (elapsed_s !== 8'd15) begin errors++; $display("FAIL ph1_wait: elapsed got %0d want 15", elapsed_s); end
    checks++; if (irq_reg !== IRQ_NONE) begin errors++; $display("FAIL ph1_early: irq got %h want FF", irq_reg); end
    tick(1);
    checks++; if (irq_reg !== IRQ_PH1) begin errors++; $display("FAIL ph1_post: irq got %h want %h", irq_reg, IRQ_PH1); end
    checks++; if (phase !== 3'(PH1)) begin errors++; $display("FAIL ph1_phase: got %0d want %0d", phase, PH1); end
    $display("test_phase1: elapsed=%0d irq=%h", elapsed_s, irq_reg);
  endtask

  task automatic test_async_reset();
    #2 reset_x = 1'b0;
    #1;
    checks++; if (irq_reg !== IRQ_BOOT) begin errors++; $display("FAIL areset_irq: got %h want %h", irq_reg, IRQ_BOOT); end
    checks++; if (phase !== 3'(BOOT)) begin errors++; $display("FAIL areset_phase: got %0d want %0d", phase, BOOT); end
    checks++; if (elapsed_s !== 8'd0) begin errors++; $display("FAIL areset_elapsed: got %0d want 0", elapsed_s); end
    checks++; if (irq_pending !== 1'b1 || hd_sd_x !== 1'b1 || reg_video_format !== 8'h00) begin
      errors++; $display("FAIL areset_misc: pend=%b hdsd=%b fmt=%h want 1 1 00", irq_pending, hd_sd_x, reg_video_format); end
    id_read = 1'b0; irq_clr_tgl = 1'b0;
    tick(3);
    reset_x = 1'b1;
    $display("test_async_reset: irq=%h phase=%0d", irq_reg, phase);
  endtask

  task automatic test_phase2();
    int n = 0;
    irq_clr_tgl = ~irq_clr_tgl;
    while (irq_reg !== IRQ_NONE && n < 5) begin tick(1); n++; end
    checks++; if (irq_reg !== IRQ_NONE) begin errors++; $display("FAIL ph1_clr: irq got %h want FF", irq_reg); end
    n = 0;
    while (elapsed_s !== 8'd22 && n < 20000) begin tick(1); n++; end
    checks++; if (irq_reg !== IRQ_NONE || elapsed_s !== 8'd22) begin
      errors++; $display("FAIL ph2_early: irq got %h elapsed %0d want FF at 22", irq_reg, elapsed_s); end
    tick(1);
    checks++; if (irq_reg !== IRQ_PH2) begin errors++; $display("FAIL ph2_post: irq got %h want %h", irq_reg, IRQ_PH2); end
    checks++; if (phase !== 3'(PH2)) begin errors++; $display("FAIL ph2_phase: got %0d want %0d", phase, PH2); end
    irq_clr_tgl = ~irq_clr_tgl;
    n = 0;
    while (phase !== 3'(RUN) && n < 6) begin tick(1); n++; end
    checks++; if (phase !== 3'(RUN)) begin errors++; $display("FAIL run_phase: got %0d want %0d", phase, RUN); end
    $display("test_phase2: elapsed=%0d phase=%0d", elapsed_s, phase);
  endtask

  task automatic test_format_post();
    int k = 0;
    video_format = FMT_480I;
    while (irq_reg !== IRQ_FMT && k < 300) begin tick(1); k++; end
    checks++; if (k != 102) begin errors++; $display("FAIL fmt_latency: got %0d cycles want 102", k); end
    checks++; if (reg_video_format !== FMT_480I) begin errors++; $display("FAIL fmt_reg: got %h want %h", reg_video_format, FMT_480I); end
    checks++; if (hd_sd_x !== 1'b0 || irq_pending !== 1'b1) begin
      errors++; $display("FAIL fmt_hdsd: hdsd %b pend %b want 0 1", hd_sd_x, irq_pending); end
    $display("test_format_post: irq=%h fmt=%h hdsd=%b", irq_reg, reg_video_format, hd_sd_x);
  endtask

  task automatic test_held_change();
    int n = 0;
    video_format = FMT_480P;
    tick(200);
    checks++; if (irq_reg !== IRQ_FMT || reg_video_format !== FMT_480I) begin
      errors++; $display("FAIL held_wait: irq %h fmt %h want DF 02", irq_reg, reg_video_format); end
    irq_clr_tgl = ~irq_clr_tgl;
    while (irq_reg === IRQ_FMT && n < 6) begin tick(1); n++; end
    checks++; if (irq_reg !== IRQ_NONE) begin errors++; $display("FAIL held_clr: irq got %h want FF", irq_reg); end
    tick(1);
    checks++; if (irq_reg !== IRQ_FMT) begin errors++; $display("FAIL held_post: irq got %h want DF", irq_reg); end
    checks++; if (reg_video_format !== FMT_480P || hd_sd_x !== 1'b1) begin
      errors++; $display("FAIL held_fmt: fmt %h hdsd %b want 04 1", reg_video_format, hd_sd_x); end
    $display("test_held_change: irq=%h fmt=%h", irq_reg, reg_video_format);
  endtask

  task automatic test_glitch();
    int n = 0;
    int busy = 0;
    irq_clr_tgl = ~irq_clr_tgl;
    while (irq_reg !== IRQ_NONE && n < 6) begin tick(1); n++; end
    video_format = FMT_576I;
    for (int i = 0; i < 50; i++) begin tick(1); if (irq_reg !== IRQ_NONE) busy++; end
    video_format = FMT_480P;
    for (int i = 0; i < 200; i++) begin tick(1); if (irq_reg !== IRQ_NONE) busy++; end
    checks++; if (busy != 0) begin errors++; $display("FAIL glitch_event: %0d non-FF cycles want 0", busy); end
    checks++; if (reg_video_format !== FMT_480P) begin errors++; $display("FAIL glitch_fmt: got %h want 04", reg_video_format); end
    $display("test_glitch: irq=%h fmt=%h", irq_reg, reg_video_format);
  endtask

  task automatic test_coincident();
    video_format = FMT_576P;
    tick(99);
    // Sync delay puts the clear pulse on the same cycle the debounce completes.
    irq_clr_tgl = ~irq_clr_tgl;
    tick(3);
    checks++; if (irq_reg !== IRQ_NONE) begin errors++; $display("FAIL coinc_clr_first: irq got %h want FF", irq_reg); end
    tick(1);
    checks++; if (irq_reg !== IRQ_FMT || reg_video_format !== FMT_576P) begin
      errors++; $display("FAIL coinc_post: irq %h fmt %h want DF 03", irq_reg, reg_video_format); end
    $display("test_coincident: irq=%h fmt=%h", irq_reg, reg_video_format);
  endtask

  task automatic test_pending_timeout();
`ifdef MON_EVT_WATCHDOG_EN
    int n = 0;
    while (irq_reg !== IRQ_NONE && n < 6000) begin tick(1); n++; end
    checks++; if (irq_reg !== IRQ_NONE) begin errors++; $display("FAIL wdt_drop: irq got %h want FF", irq_reg); end
    tick(1);
    checks++; if (irq_reg !== IRQ_FMT) begin errors++; $display("FAIL wdt_repost: irq got %h want DF", irq_reg); end
    checks++; if (wdt_retries !== 4'd1) begin errors++; $display("FAIL wdt_retries: got %0d want 1", wdt_retries); end
`else
    int busy = 0;
    for (int i = 0; i < 6000; i++) begin tick(1); if (irq_reg !== IRQ_FMT) busy++; end
    checks++; if (busy != 0) begin errors++; $display("FAIL pend_hold: %0d cycles not DF want 0", busy); end
`endif
    $display("test_pending_timeout: irq=%h", irq_reg);
  endtask

  initial begin
    test_reset();
    test_boot_clear();
    test_phase1();
    test_async_reset();
    test_boot_clear();
    test_phase1();
    test_phase2();
    test_format_post();
    test_held_change();
    test_glitch();
    test_coincident();
    test_pending_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/monitor_event_scheduler.md
Name: monitor_event_scheduler

Overview:
- Sequences the slot's interrupt/event register (host register 0x41) toward the BVM-A monitor, on the 50 MHz domain.
- Drives the power-up handshake: boot, ID-read wait, phase-1 (FB), phase-2 (EF), then video-format-change events (DF) with debounce.
- Accepts IRQ-clear requests from the bus-strobe (clk_rw) domain via toggle synchronizer.
- Feeds irq register value, latched format and HD/SD select to the bus interface.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- PH1_BASE_S, 12, phase-1 threshold (s) for slot 2.
- PH2_BASE_S, 19, phase-2 threshold (s) for slot 2.
- SLOT_STEP_S, 2, extra seconds per slot above 2.
- FMT_STABLE_MS, 100, ms video_format must be stable before posting.

Ports:
- clk_50mhz_in  in  1  system clock
- reset_x  in  1  reset; asynchronous, active-low
- slot_no  in  8  slot number written by host (quasi-static)
- id_read  in  1  level, set once ID register read (other domain; 2-flop synced)
- irq_clr_tgl  in  1  toggles once per host write to 0x41 (other domain)
- video_format  in  8  live format code from detector
- irq_reg  out  8  value of register 0x41
- irq_pending  out  1  irq_reg != 8'hFF
- reg_video_format  out  8  format last posted to monitor
- hd_sd_x  out  1  0 when reg_video_format is 1 or 2, else 1
- phase  out  3  current state encoding
- elapsed_s  out  8  seconds since reset, saturating at 255

Behaviour:
- Reset values: irq_reg=FD, irq_pending=1, reg_video_format=00, hd_sd_x=1, phase=BOOT, elapsed_s=0, all counters 0.
- Clear path:
  - Sync irq_clr_tgl through 3 flops; an edge between flops 2 and 3 is a one-cycle clr pulse.
  - clr sets irq_reg=FF on the next clock.
- Ticks: ms tick every CLK_HZ/1000 cycles; s tick every CLK_HZ cycles; elapsed_s saturates at 255, no wrap.
- Thresholds:
  - Slot 3 → base+STEP; slot 4 → base+2*STEP; any other slot → base.
  - Comparison is strict (elapsed_s > thr).
  - Threshold evaluated each cycle, so a late slot_no write takes effect immediately.
- States:
  - BOOT: wait irq_reg==FF → WAIT_ID.
  - WAIT_ID: id_read_sync && elapsed_s>PH1 → irq_reg=FB, PH1.
  - PH1: irq_reg==FF && elapsed_s>PH2 → irq_reg=EF, PH2.
  - PH2: irq_reg==FF → RUN.
  - RUN: debounced format ≠ reg_video_format && irq_reg==FF → reg_video_format=format, irq_reg=DF (same cycle).
- Debounce:
  - ms counter reloads whenever video_format changes.
  - Stable after FMT_STABLE_MS consecutive ms ticks with no change.
  - Debounce runs in every state; only RUN posts.
  - A change arriving while DF is pending is held, then posted after clear.
  - If format returns to reg_video_format before posting, nothing is posted.
- Simultaneous clr and post condition in one cycle: clear wins (FF); the post is evaluated next cycle, so one idle FF cycle is guaranteed between events.
- clr in BOOT with no prior event: BOOT→WAIT_ID as above.
- Async reset mid-operation: returns to reset values immediately; synchronizer flops also reset.

Optional Feature:
- MON_EVT_WATCHDOG_EN:
  - Defined: if irq_pending remains for 5 s in PH1/PH2/RUN, irq_reg is forced to FF for one cycle, then the same code is re-posted.
  - Adds output wdt_retries[3:0], saturating at 15.
- Undefined: no re-post; a pending event waits indefinitely; port absent.

Decomposition:
- Package mon_evt_pkg:
  - IRQ codes IRQ_NONE=FF, IRQ_BOOT=FD, IRQ_PH1=FB, IRQ_PH2=EF, IRQ_FMT=DF.
  - Phase enum BOOT/WAIT_ID/PH1/PH2/RUN.
  - Format codes NO_SIGNAL=0, 576I=1, 480I=2, 576P=3, 480P=4.
- Sub-module mon_tick_gen: ms/s tick dividers and the saturating elapsed_s counter.

Test Plan:
- Reset, CLK_HZ scaled to 1000 → irq_reg=FD, hd_sd_x=1; one clr toggle → FF within 4 cycles, phase=WAIT_ID.
- slot_no=3, id_read=1 at 5 s → FB appears at first cycle elapsed_s=15; clr then → EF when elapsed_s=22.
- RUN, video_format 00→02 held 100 ms → irq_reg=DF, reg_video_format=02, hd_sd_x=0; glitch of 50 ms → no event.
- DF pending, format 02→04 → no new post until clr; after clr exactly one FF cycle, then DF with reg_video_format=04, hd_sd_x=1.
- clr toggle coincident with debounced change → FF first, DF next cycle; reset_x low mid-PH1 → all outputs to reset values asynchronously.
- With MON_EVT_WATCHDOG_EN: no clr for 5 s after DF → one FF cycle, DF re-posted, wdt_retries=1.
